// File: rtl/note_display_pkg.sv
// Shared definitions for the note-display path: block ROM word layout,
// sequencer states and the fixed song table.
package note_display_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned SIZE_W    = 3;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned WORD_W    = 15;
  localparam int unsigned SONG_W    = 2;
  localparam int unsigned NUM_ENTRY = 4;

  // Block ROM word: {start_addr[8:0], prev_size[2:0], curr_size[2:0]}
  localparam int unsigned START_MSB = 14;
  localparam int unsigned START_LSB = 6;
  localparam int unsigned PREV_MSB  = 5;
  localparam int unsigned PREV_LSB  = 3;
  localparam int unsigned CURR_MSB  = 2;
  localparam int unsigned CURR_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] SONG_BASE  [NUM_ENTRY] = '{9'd0, 9'd16, 9'd48, 9'd64};
  localparam logic [IDX_W-1:0]  SONG_COUNT [NUM_ENTRY] = '{6'd16, 6'd32, 6'd16, 6'd32};

  function automatic logic [ADDR_W-1:0] song_base(input logic [SONG_W-1:0] sel);
    case (sel)
      2'd0:    return SONG_BASE[0];
      2'd1:    return SONG_BASE[1];
      2'd2:    return SONG_BASE[2];
      default: return SONG_BASE[3];
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] song_count(input logic [SONG_W-1:0] sel);
    case (sel)
      2'd0:    return SONG_COUNT[0];
      2'd1:    return SONG_COUNT[1];
      2'd2:    return SONG_COUNT[2];
      default: return SONG_COUNT[3];
    endcase
  endfunction

endpackage

// File: rtl/note_block_sequencer.sv
// Walks a song's blocks through the block ROM and steps note addresses on
// tempo ticks; all outputs are registered from the next-state values.
module note_block_sequencer
  import note_display_pkg::*;
#(
  parameter bit          LOOP      = 1'b0,
  parameter int unsigned NUM_SONGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              advance,
  output logic [ADDR_W-1:0] block_addr,
  input  logic [WORD_W-1:0] block_dout,
  output logic [ADDR_W-1:0] note_addr,
  output logic              note_valid,
  output logic [SIZE_W-1:0] curr_size,
  output logic [SIZE_W-1:0] prev_size,
  output logic [IDX_W-1:0]  block_idx,
  output logic              busy,
  output logic              song_done
);

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [ADDR_W-1:0]   block_addr_q, block_addr_d;
  logic [IDX_W-1:0]    block_idx_q, block_idx_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [SIZE_W-1:0]   offset_q, offset_d;
  logic [SIZE_W-1:0]   curr_size_q, curr_size_d;
  logic [SIZE_W-1:0]   prev_size_q, prev_size_d;
  logic [ADDR_W-1:0]   note_addr_q, note_addr_d;
  logic                note_valid_q, note_valid_d;
  logic                busy_q, busy_d;
  logic                song_done_q, song_done_d;
  logic                end_of_block;
  logic                start_ok;

  // Out-of-table song indices are ignored when the table is shrunk.
  assign start_ok = start && (32'(song_sel) < NUM_SONGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      song_q       <= '0;
      block_addr_q <= '0;
      block_idx_q  <= '0;
      start_addr_q <= '0;
      offset_q     <= '0;
      curr_size_q  <= '0;
      prev_size_q  <= '0;
      note_addr_q  <= '0;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      block_addr_q <= block_addr_d;
      block_idx_q  <= block_idx_d;
      start_addr_q <= start_addr_d;
      offset_q     <= offset_d;
      curr_size_q  <= curr_size_d;
      prev_size_q  <= prev_size_d;
      note_addr_q  <= note_addr_d;
      note_valid_q <= note_valid_d;
      busy_q       <= busy_d;
      song_done_q  <= song_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    song_d       = song_q;
    block_addr_d = block_addr_q;
    block_idx_d  = block_idx_q;
    start_addr_d = start_addr_q;
    offset_d     = offset_q;
    curr_size_d  = curr_size_q;
    prev_size_d  = prev_size_q;
    end_of_block = 1'b0;

    case (state_q)
      IDLE:  ;
      FETCH: state_d = LOAD;
      LOAD: begin
        start_addr_d = block_dout[START_MSB:START_LSB];
        prev_size_d  = block_dout[PREV_MSB:PREV_LSB];
        curr_size_d  = block_dout[CURR_MSB:CURR_LSB];
        offset_d     = '0;
        // An empty block contributes no notes and moves straight on.
        if (block_dout[CURR_MSB:CURR_LSB] == '0) end_of_block = 1'b1;
        else                                     state_d      = PLAY;
      end
      PLAY: begin
        if (advance) begin
          if (offset_q == curr_size_q - SIZE_W'(1)) end_of_block = 1'b1;
          else                                      offset_d     = offset_q + SIZE_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (end_of_block) begin
      if (block_idx_q < song_count(song_q) - IDX_W'(1)) begin
        block_addr_d = block_addr_q + ADDR_W'(1);
        block_idx_d  = block_idx_q + IDX_W'(1);
        state_d      = FETCH;
      end else if (LOOP) begin
        block_addr_d = song_base(song_q);
        block_idx_d  = '0;
        state_d      = FETCH;
      end else begin
        state_d = DONE;
      end
    end

    // Restart wins over everything, including a pending DONE.
    if (start_ok) begin
      song_d       = song_sel;
      block_addr_d = song_base(song_sel);
      block_idx_d  = '0;
      state_d      = FETCH;
    end
  end

  always_comb begin
    note_valid_d = (state_d == PLAY);
    busy_d       = (state_d != IDLE);
    song_done_d  = (state_d == DONE);
    note_addr_d  = start_addr_d + ADDR_W'(offset_d);
  end

  assign block_addr = block_addr_q;
  assign note_addr  = note_addr_q;
  assign note_valid = note_valid_q;
  assign curr_size  = curr_size_q;
  assign prev_size  = prev_size_q;
  assign block_idx  = block_idx_q;
  assign busy       = busy_q;
  assign song_done  = song_done_q;

endmodule

// File: tb/tb_note_block_sequencer.sv
// Scoreboard bench: stimulus queues expected note/done events, a negedge
// monitor pops and compares them as the sequencer presents them.
module tb_note_block_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, advance;
  logic [1:0]  song_sel;
  logic [8:0]  empty_addr;

  logic [8:0]  block_addr, note_addr;
  logic [14:0] block_dout;
  logic        note_valid, busy, song_done;
  logic [2:0]  curr_size, prev_size;
  logic [5:0]  block_idx;

  logic [8:0]  l_block_addr, l_note_addr;
  logic [14:0] l_block_dout;
  logic        l_note_valid, l_busy, l_song_done;
  logic [2:0]  l_curr_size, l_prev_size;
  logic [5:0]  l_block_idx;

  typedef struct packed {
    logic       is_done;
    logic [8:0] na;
    logic [8:0] ba;
    logic [2:0] cs;
    logic [2:0] ps;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   l_done_cnt = 0;

  always #5 clk = ~clk;

  note_block_sequencer #(.LOOP(1'b0), .NUM_SONGS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .song_sel(song_sel), .advance(advance),
    .block_addr(block_addr), .block_dout(block_dout), .note_addr(note_addr),
    .note_valid(note_valid), .curr_size(curr_size), .prev_size(prev_size),
    .block_idx(block_idx), .busy(busy), .song_done(song_done)
  );

  note_block_sequencer #(.LOOP(1'b1), .NUM_SONGS(4)) dut_loop (
    .clk(clk), .rst(rst), .start(start), .song_sel(song_sel), .advance(advance),
    .block_addr(l_block_addr), .block_dout(l_block_dout), .note_addr(l_note_addr),
    .note_valid(l_note_valid), .curr_size(l_curr_size), .prev_size(l_prev_size),
    .block_idx(l_block_idx), .busy(l_busy), .song_done(l_song_done)
  );

  // Block ROM contents: song0 blocks of 4 notes at 4*b, others 2 notes each.
  function automatic logic [14:0] rom_word(input logic [8:0] a);
    int ai, st, cs, ps;
    ai = int'(a);
    if (ai < 16)      begin st = 4*ai;            cs = 4; ps = (ai == 0)  ? 0 : 4; end
    else if (ai < 48) begin st = 128 + 2*(ai-16); cs = 2; ps = (ai == 16) ? 0 : 2; end
    else if (ai < 64) begin st = 256 + 2*(ai-48); cs = 2; ps = (ai == 48) ? 0 : 2; end
    else if (ai < 96) begin st = 384 + 2*(ai-64); cs = 2; ps = (ai == 64) ? 0 : 2; end
    else              begin st = 0;               cs = 0; ps = 0;                  end
    if (a == empty_addr) cs = 0;
    return {9'(st), 3'(ps), 3'(cs)};
  endfunction

  always @(posedge clk) begin
    block_dout   <= rom_word(block_addr);
    l_block_dout <= rom_word(l_block_addr);
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_note(input int na, input int ba, input int cs, input int ps);
    exp_t e;
    e.is_done = 1'b0;
    e.na = 9'(na);
    e.ba = 9'(ba);
    e.cs = 3'(cs);
    e.ps = 3'(ps);
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: a note is consumed when valid with advance and no restart.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (note_valid && advance && !start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_note", int'(note_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("note_not_done", int'(e.is_done), 0);
          check("note_addr", int'(note_addr), int'(e.na));
          check("note_block_addr", int'(block_addr), int'(e.ba));
          check("note_curr_size", int'(curr_size), int'(e.cs));
          check("note_prev_size", int'(prev_size), int'(e.ps));
        end
      end
      if (song_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_song_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("song_done_expected", int'(e.is_done), 1);
        end
      end
      if (l_song_done) l_done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  found;
    bit  saw_empty;

    rst = 1'b1; start = 1'b0; advance = 1'b0; song_sel = 2'd0; empty_addr = 9'd511;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_block_addr", int'(block_addr), 0);
    check("rst_note_addr", int'(note_addr), 0);
    check("rst_note_valid", int'(note_valid), 0);
    check("rst_curr_size", int'(curr_size), 0);
    check("rst_prev_size", int'(prev_size), 0);
    check("rst_block_idx", int'(block_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_song_done", int'(song_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Song0: latency and first block
    @(posedge clk); #1 start = 1'b1; song_sel = 2'd0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("fetch_block_addr", int'(block_addr), 0);
    check("fetch_busy", int'(busy), 1);
    check("fetch_note_valid", int'(note_valid), 0);
    @(negedge clk);
    check("load_note_valid", int'(note_valid), 0);
    @(negedge clk);
    check("first_note_valid", int'(note_valid), 1);
    check("first_note_addr", int'(note_addr), 0);
    check("first_curr_size", int'(curr_size), 4);
    check("first_prev_size", int'(prev_size), 0);

    for (int i = 0; i < 4; i++) push_note(i, 0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 advance = 1'b1;
      @(posedge clk); #1 advance = 1'b0;
    end
    @(negedge clk);
    check("gap1_note_valid", int'(note_valid), 0);
    check("gap1_block_addr", int'(block_addr), 1);
    check("gap1_block_idx", int'(block_idx), 1);
    @(negedge clk);
    check("gap2_note_valid", int'(note_valid), 0);
    @(negedge clk);
    check("blk1_note_valid", int'(note_valid), 1);
    check("blk1_note_addr", int'(note_addr), 4);
    check("blk1_prev_size", int'(prev_size), 4);

    // Advance to note 9, then restart with song3
    for (int i = 4; i < 8; i++) push_note(i, 1, 4, 4);
    push_note(8, 2, 4, 4);
    @(posedge clk); #1 advance = 1'b1;
    repeat (7) @(posedge clk);
    #1 advance = 1'b0;
    @(negedge clk);
    check("pre_restart_note_addr", int'(note_addr), 9);
    @(posedge clk); #1 start = 1'b1; song_sel = 2'd3; advance = 1'b1;
    @(posedge clk); #1 start = 1'b0; advance = 1'b0;
    @(negedge clk);
    check("restart_block_addr", int'(block_addr), 64);
    check("restart_note_valid", int'(note_valid), 0);
    check("restart_block_idx", int'(block_idx), 0);
    check("restart_song_done", int'(song_done), 0);
    @(negedge clk);
    @(negedge clk);
    check("song3_note_valid", int'(note_valid), 1);
    check("song3_note_addr", int'(note_addr), 384);
    check("song3_curr_size", int'(curr_size), 2);

    // Song1 with advance held high
    for (int b = 0; b < 32; b++) begin
      push_note(128 + 2*b, 16 + b, 2, (b == 0) ? 0 : 2);
      push_note(129 + 2*b, 16 + b, 2, (b == 0) ? 0 : 2);
    end
    push_done();
    @(posedge clk); #1 start = 1'b1; song_sel = 2'd1; advance = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 400);
    check("song1_finished_busy", int'(busy), 0);
    check("song1_done_count", done_cnt, 1);
    check("song1_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("idle_song_done", int'(song_done), 0);

    // Song2: looping instance wraps, plain instance finishes
    for (int b = 0; b < 16; b++) begin
      push_note(256 + 2*b, 48 + b, 2, (b == 0) ? 0 : 2);
      push_note(257 + 2*b, 48 + b, 2, (b == 0) ? 0 : 2);
    end
    push_done();
    @(posedge clk); #1 start = 1'b1; song_sel = 2'd2;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    found = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      found = l_note_valid && (l_block_addr == 9'd63) && (l_note_addr == 9'd287);
    end while (!found && cyc < 300);
    check("loop_reached_last_note", int'(found), 1);
    @(negedge clk);
    check("loop_wrap_block_addr", int'(l_block_addr), 48);
    check("loop_wrap_note_valid", int'(l_note_valid), 0);
    check("loop_wrap_song_done", int'(l_song_done), 0);
    check("loop_wrap_busy", int'(l_busy), 1);
    @(negedge clk);
    @(negedge clk);
    check("loop_first_note_valid", int'(l_note_valid), 1);
    check("loop_first_note_addr", int'(l_note_addr), 256);
    check("loop_first_block_idx", int'(l_block_idx), 0);
    @(posedge clk); #1 advance = 1'b0;
    @(negedge clk);
    check("song2_done_count", done_cnt, 2);

    // Song0 with an empty block 2, then reset mid-play
    empty_addr = 9'd2;
    for (int i = 0; i < 4; i++) push_note(i, 0, 4, 0);
    for (int i = 4; i < 8; i++) push_note(i, 1, 4, 4);
    push_note(12, 3, 4, 4);
    push_note(13, 3, 4, 4);
    @(posedge clk); #1 start = 1'b1; song_sel = 2'd0;
    @(posedge clk); #1 start = 1'b0; advance = 1'b1;
    cyc = 0;
    found = 1'b0;
    saw_empty = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (note_valid && block_addr == 9'd2) saw_empty = 1'b1;
      found = note_valid && (note_addr == 9'd13);
    end while (!found && cyc < 100);
    check("empty_reached_note13", int'(found), 1);
    check("empty_block_no_note", int'(saw_empty), 0);
    #2 rst = 1'b1; advance = 1'b0;
    @(negedge clk);
    check("midrst_block_addr", int'(block_addr), 0);
    check("midrst_note_addr", int'(note_addr), 0);
    check("midrst_note_valid", int'(note_valid), 0);
    check("midrst_curr_size", int'(curr_size), 0);
    check("midrst_prev_size", int'(prev_size), 0);
    check("midrst_block_idx", int'(block_idx), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_song_done", int'(song_done), 0);
    check("midrst_loop_busy", int'(l_busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("final_done_count", done_cnt, 2);
    check("loop_never_done", l_done_cnt, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
